// File: rtl/gate_truth_checker.sv
// Stimulus/check wrapper for a 2-input cell: walks {A2,A1} through all vectors and compares Y with TRUTH.
// Optional GATE_TRUTH_CHECKER_SYNC_EN: double-flop y_in and stretch each settle phase by 2 cycles.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOOPS         = 16,
  parameter logic [3:0]  TRUTH         = 4'b0001,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  output logic             a1,
  output logic             a2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned LOOP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [LOOP_W-1:0] r_loop;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_drv;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_fail;

  logic             w_y;
  logic             w_mismatch;
  logic             w_last;
  logic [ERR_W-1:0] w_err_next;
  logic [3:0]       w_fail_next;

`ifdef GATE_TRUTH_CHECKER_SYNC_EN
  // Two extra settle cycles cover the synchroniser latency.
  localparam int unsigned SETTLE_LOAD = SETTLE_CYCLES + 1;
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], y_in};
  end

  assign w_y = r_sync[1];
`else
  localparam int unsigned SETTLE_LOAD = SETTLE_CYCLES - 1;
  assign w_y = y_in;
`endif

  // Compare result and the error state it would produce if this is a SAMPLE cycle.
  assign w_mismatch  = (w_y != TRUTH[r_vec]);
  assign w_err_next  = (w_mismatch && (r_err != {ERR_W{1'b1}})) ? r_err + ERR_W'(1) : r_err;
  assign w_fail_next = w_mismatch ? (r_fail | (4'b0001 << r_vec)) : r_fail;
  assign w_last      = (r_vec == 2'd3) && (r_loop == LOOP_W'(LOOPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vec   <= 2'd0;
      r_loop  <= '0;
      r_cnt   <= '0;
      r_drv   <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        // Abort keeps partial error results but never reports a pass.
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_drv   <= 2'd0;
        r_pass  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_state <= ST_SETTLE;
              r_vec   <= 2'd0;
              r_loop  <= '0;
              r_cnt   <= CNT_W'(SETTLE_LOAD);
              r_drv   <= 2'd0;
              r_err   <= '0;
              r_fail  <= 4'd0;
              r_pass  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (r_cnt == '0) r_state <= ST_SAMPLE;
            else             r_cnt   <= r_cnt - CNT_W'(1);
          end
          ST_SAMPLE: begin
            r_err  <= w_err_next;
            r_fail <= w_fail_next;
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_state <= ST_SETTLE;
              r_vec   <= r_vec + 2'd1;
              r_drv   <= r_vec + 2'd1;
              r_cnt   <= CNT_W'(SETTLE_LOAD);
              if (r_vec == 2'd3) r_loop <= r_loop + LOOP_W'(1);
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_drv   <= 2'd0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign a1        = r_drv[0];
  assign a2        = r_drv[1];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed/randomised bench for gate_truth_checker; models the cell as a lookup of its actual truth table.
// Honors GATE_TRUTH_CHECKER_SYNC_EN for the per-vector period.
module tb_gate_truth_checker;

  localparam int unsigned S  = 4;
  localparam int unsigned L  = 16;
  localparam logic [3:0]  TT = 4'b0001;
`ifdef GATE_TRUTH_CHECKER_SYNC_EN
  localparam int P = S + 3;
`else
  localparam int P = S + 1;
`endif
  localparam int N = 4 * L * P;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] tt_act = TT;

  logic       m_a1, m_a2, m_busy, m_done, m_pass, m_y;
  logic [7:0] m_err;
  logic [3:0] m_fail;
  logic       s_a1, s_a2, s_busy, s_done, s_pass, s_y;
  logic [3:0] s_err;
  logic [3:0] s_fail;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Cell under test: its real behaviour is whatever truth table tt_act holds.
  assign m_y = tt_act[{m_a2, m_a1}];
  assign s_y = tt_act[{s_a2, s_a1}];

  gate_truth_checker #(.SETTLE_CYCLES(S), .LOOPS(L), .TRUTH(TT), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(m_y),
    .a1(m_a1), .a2(m_a2), .busy(m_busy), .done(m_done), .pass(m_pass),
    .err_count(m_err), .fail_vec(m_fail)
  );

  gate_truth_checker #(.SETTLE_CYCLES(S), .LOOPS(L), .TRUTH(TT), .ERR_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(s_y),
    .a1(s_a1), .a2(s_a2), .busy(s_busy), .done(s_done), .pass(s_pass),
    .err_count(s_err), .fail_vec(s_fail)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: mismatches seen in the SAMPLE slots of the first ncyc cycles after start acceptance.
  task automatic expect_after(input int ncyc, output int cnt, output logic [3:0] fv);
    cnt = 0;
    fv  = 4'd0;
    for (int j = 0; j < ncyc; j++) begin
      if ((j % P) == (P - 1)) begin
        int v;
        v = (j / P) % 4;
        if (tt_act[v] != TT[v]) begin
          cnt++;
          fv[v] = 1'b1;
        end
      end
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_m_out"}, {m_a2, m_a1, m_busy, m_done, m_pass, m_err, m_fail}, 0);
    check({tag, "_s_out"}, {s_a2, s_a1, s_busy, s_done, s_pass, s_err, s_fail}, 0);
  endtask

  // One run from start acceptance; optional abort, extra start pulse, or async reset at cycle k.
  task automatic run(input string tag, input int abort_at, input int restart_at, input int reset_at);
    int cnt;
    logic [3:0] fv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == reset_at) begin
        #1 rst_n = 1'b0;
        #1;
        check_all_zero({tag, "_async_rst"});
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (k == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        expect_after(k, cnt, fv);
        check({tag, "_abort_busy"}, m_busy, 0);
        check({tag, "_abort_a"}, {m_a2, m_a1}, 0);
        check({tag, "_abort_pass"}, m_pass, 0);
        check({tag, "_abort_err"}, m_err, sat(cnt, 255));
        check({tag, "_abort_fail"}, m_fail, fv);
        check({tag, "_abort_sat_err"}, s_err, sat(cnt, 15));
        for (int j = 0; j < 20; j++) begin
          check({tag, "_abort_nodone"}, {m_done, s_done}, 0);
          @(posedge clk); #1;
        end
        return;
      end
      check({tag, "_vec"}, {m_a2, m_a1}, (k / P) % 4);
      check({tag, "_busy"}, {m_busy, s_busy}, 2'b11);
      check({tag, "_done_low"}, {m_done, s_done}, 0);
      start = (k == restart_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    expect_after(N, cnt, fv);
    check({tag, "_done"}, {m_done, s_done}, 2'b11);
    check({tag, "_end_busy"}, {m_busy, s_busy}, 0);
    check({tag, "_pass"}, m_pass, (cnt == 0));
    check({tag, "_err"}, m_err, sat(cnt, 255));
    check({tag, "_fail"}, m_fail, fv);
    check({tag, "_sat_pass"}, s_pass, (cnt == 0));
    check({tag, "_sat_err"}, s_err, sat(cnt, 15));
    check({tag, "_sat_fail"}, s_fail, fv);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {m_done, s_done}, 0);
    check({tag, "_idle_a"}, {m_a2, m_a1}, 0);
    check({tag, "_hold_err"}, m_err, sat(cnt, 255));
    check({tag, "_hold_pass"}, m_pass, (cnt == 0));
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    tt_act = TT;       run("ideal", -1, -1, -1);
    tt_act = 4'b0000;  run("stuck0", -1, -1, -1);
    tt_act = 4'b1111;  run("stuck1", -1, -1, -1);
    for (int r = 0; r < 3; r++) begin
      tt_act = 4'($urandom);
      run("rand_tt", -1, -1, -1);
    end

    tt_act = TT;       run("abort100", 100, -1, -1);
    run("after_abort", -1, -1, -1);
    tt_act = 4'($urandom);
    run("rand_abort", int'($urandom_range(10, N - 10)), -1, -1);

    // abort beats start while idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("idle_abort_start_busy", {m_busy, s_busy}, 0);
    @(posedge clk); #1;
    check("idle_abort_start_a", {m_a2, m_a1}, 0);

    tt_act = 4'b1111;  run("restart_reset", -1, 50, 200);
    check_all_zero("post_reset");
    tt_act = TT;       run("final_ideal", -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Sequential stimulus/check stage wrapped around a 2-input library cell under test (NOR2 by default).
- Upstream role: drives the cell's A1/A2 inputs through all four input vectors.
- Downstream role: samples the cell's Y output after a programmable settle time and compares it against a parameterised truth table.
- Used for in-silicon and simulation validation of transistor-level cells; reports error count, per-vector failure flags and an overall pass bit.

Parameters:
- SETTLE_CYCLES, 4: cycles each vector is held before Y is sampled; legal range 1..255.
- LOOPS, 16: full passes over the 4 vectors per run; legal range 1..65535.
- TRUTH, 4'b0001: expected Y per vector index {A2,A1}; bit i is the expected Y for vector i; the default is NOR.
- ERR_W, 8: width of err_count.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  synchronous abort; ends a run without done.
- y_in  in  1  Y output of the cell under test.
- a1  out  1  drives cell A1; registered.
- a2  out  1  drives cell A2; registered.
- busy  out  1  high from the start-accept edge until the run ends.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  high when the last completed run had zero errors.
- err_count  out  ERR_W  saturating mismatch count for the current or last run.
- fail_vec  out  4  sticky per-vector mismatch flags for the current or last run.

Behaviour:
- Reset values (while rst_n low): a1=0, a2=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0; FSM=IDLE.
- Reset is asynchronous and may occur mid-run. The FSM goes to IDLE and all outputs clear.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - vec=0, loop=0, settle_cnt=SETTLE_CYCLES-1.
  - err_count=0, fail_vec=0, pass=0, busy=1.
  - Next state SETTLE.
- Drive rule: {a2,a1} = vec, registered in every non-IDLE state. {a2,a1}=0 in IDLE.
- SETTLE: settle_cnt decrements each cycle. When settle_cnt==0, next state is SAMPLE.
- SAMPLE:
  - On mismatch (y_in != TRUTH[vec]): err_count+1, saturating at 2^ERR_W-1; fail_vec[vec]=1.
  - If vec==3 and loop==LOOPS-1, next state DONE.
  - Otherwise vec increments, wrapping 3->0 and incrementing loop on wrap; settle_cnt reloads; next state SETTLE.
- DONE:
  - done=1 for this single cycle; busy=0; pass=(err_count==0).
  - On the DONE cycle the final SAMPLE's increment is already included.
  - Next state IDLE.
- Timing:
  - Each vector occupies exactly SETTLE_CYCLES+1 cycles.
  - done rises 4*LOOPS*(SETTLE_CYCLES+1) cycles after the edge that accepted start.
- start while busy: ignored; it does not restart or extend the run.
- start asserted on the DONE cycle: ignored. start is accepted on the following IDLE cycle if still held.
- abort:
  - In any non-IDLE state, next state is IDLE; busy=0, a1=a2=0.
  - done is not pulsed; pass is held 0.
  - err_count and fail_vec keep their partial values.
  - abort has priority over SAMPLE updates in the same cycle.
- abort and start together in IDLE: abort wins; the run is not started.
- err_count and fail_vec hold their values in IDLE until the next accepted start.

Optional Feature:
- Macro: GATE_TRUTH_CHECKER_SYNC_EN.
- Defined:
  - y_in passes through a 2-flop synchroniser, reset to 0, before comparison.
  - Each vector's settle phase is extended by 2 cycles, so every vector takes SETTLE_CYCLES+3 cycles.
  - done latency becomes 4*LOOPS*(SETTLE_CYCLES+3).
- Not defined: y_in is compared directly; timing is as in Behaviour.

Test Plan:
- Ideal NOR model on y_in, defaults, start pulse -> a1/a2 cycle 00,01,10,11 every 5 cycles; done 320 cycles after start; pass=1, err_count=0, fail_vec=0.
- y_in stuck at 0 -> done at 320; err_count=16, fail_vec=4'b0001, pass=0.
- y_in stuck at 1, ERR_W=4 -> err_count saturates at 15; fail_vec=4'b1110; pass=0.
- abort at cycle 100 of a run -> busy falls the next cycle, a1=a2=0, no done pulse, pass=0; new start runs a full 320-cycle pass.
- start pulsed again at cycle 50 of a run, then rst_n low at cycle 200 -> second start has no effect; reset clears all outputs immediately, without waiting for a clock edge.
- Build with GATE_TRUTH_CHECKER_SYNC_EN, ideal NOR model -> done at 448 cycles, pass=1.
